alu_decode: RTL and testbench
=============================

Name: alu_decode

Overview:
- Registered decode stage that sits in front of the ALU.
- Accepts a 32-bit RV32IM instruction word over a valid/ready handshake and decodes the ALU-executable subset: OP, OP-IMM, LUI.
- Drives the ALU op code, operand selects, immediate, register indices and writeback enable from a single-entry output register.
- Flags instructions the ALU cannot execute and counts them in a saturating counter.

Parameters:
- CNT_W, 16, width of illegal-instruction counter

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instr is valid this cycle
- in_ready  out  1  stage can accept instr
- instr  in  32  RISC-V instruction word
- flush  in  1  discard held output (branch redirect)
- out_valid  out  1  decoded fields valid
- out_ready  in  1  downstream consumes output
- alu_op  out  4  ALU op code
- a_zero  out  1  1: ALU A = 0, 0: A = rs1 data
- b_imm  out  1  1: ALU B = imm, 0: B = rs2 data
- imm  out  32  sign-extended / shifted immediate
- rs1, rs2, rd  out  5 each  register indices
- regwrite  out  1  write result to rd
- illegal  out  1  instr not executable by ALU
- illegal_cnt  out  CNT_W  saturating count of accepted illegal instrs

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset: out_valid=0, all field registers=0, illegal_cnt=0. Reset asserted mid-transfer drops the held entry.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept occurs when in_valid && in_ready.
  - Latency: one cycle from accept to out_valid.
  - Back-to-back throughput: 1/cycle while out_ready=1.
  - Output fields are held stable while out_valid && !out_ready.
- flush:
  - Next edge: out_valid=0, and any instr presented that cycle is dropped.
  - in_ready is unaffected by flush.
  - A dropped instr does not increment illegal_cnt.
- ALU op codes (shared package):
  - AND=0000, OR=0001, XOR=0010, ADD=0011, SUB=0100, MUL=0101, MULH=0110, MULHU=0111, SLL=1000, SRL=1001, SRA=1010, SLT=1100, SLTU=1101.
- Decode by opcode = instr[6:0]:
  - 0110011 (OP), funct7=0000000:
    - f3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - 0110011 (OP), funct7=0100000: f3 000 SUB, 101 SRA; other f3 illegal.
  - 0110011 (OP), funct7=0000001:
    - f3 000 MUL, 001 MULH, 011 MULHU.
    - f3 010 (MULHSU) and f3 1xx (DIV/REM) illegal.
  - 0110011 (OP), any other funct7: illegal.
  - 0010011 (OP-IMM):
    - b_imm=1, imm = sign-extended instr[31:20].
    - f3 as for OP, minus SUB.
    - f3 001 requires instr[31:25]=0000000.
    - f3 101 with instr[31:25]=0000000 gives SRL; 0100000 gives SRA; any other value is illegal.
  - 0110111 (LUI): a_zero=1, b_imm=1, imm = {instr[31:12],12'b0}, op=ADD.
  - Any other opcode: illegal.
- Illegal entries:
  - illegal=1, regwrite=0, alu_op=ADD, a_zero=0, b_imm=0, imm=0.
  - rs1/rs2/rd still carry raw instr fields.
- regwrite = !illegal && rd!=0.
- rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7] are always registered.
  - For LUI and OP-IMM they are don't-care for the ALU but are still the raw fields.
- illegal_cnt:
  - Increments on each accepted illegal instr.
  - Saturates at 2^CNT_W-1; no wrap.

Decomposition:
- Package alu_pkg:
  - alu_op_t enum with the codes above.
  - Opcode constants OPC_OP, OPC_OPIMM, OPC_LUI.
  - funct7 constants F7_BASE, F7_ALT, F7_MULDIV.
- Sub-module alu_decode_comb: pure combinational instr→fields decode.
- alu_decode holds the handshake register, flush and counter.

Test Plan:
- Reset, then in_valid=1, instr=0x002081B3 (add x3,x1,x2), out_ready=1 -> next cycle: out_valid=1, alu_op=0011, b_imm=0, rd=3, rs1=1, rs2=2, regwrite=1, illegal=0.
- instr=0xFFF00093 (addi x1,x0,-1) -> b_imm=1, imm=0xFFFFFFFF, alu_op=0011. Then instr=0x123452B7 (lui x5) -> a_zero=1, imm=0x12345000.
- instr=0x4030D193 (srai x3,x1,3) -> alu_op=1010, imm[4:0]=3. Then 0x0220C1B3 (div) -> illegal=1, regwrite=0, illegal_cnt=1.
- out_ready=0 with two instrs offered -> first is held stable, in_ready=0, second not accepted. out_ready=1 -> second accepted next edge, no loss or duplication.
- flush while out_valid=1 and in_valid=1 with an illegal instr -> out_valid=0 next cycle, illegal_cnt unchanged.
- CNT_W=2, five accepted illegal instrs -> illegal_cnt=3. Assert rst_n=0 asynchronously mid-stream -> out_valid=0 and illegal_cnt=0 immediately.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the ALU decode stage.
//   alu_op_t        : 4-bit ALU operation code driven to the ALU
//   OPC_*           : RV32 major opcodes handled by the ALU decoder
//   F7_*            : funct7 patterns that select base / alternate / mul-div
//   base_op()       : funct3 -> op mapping shared by OP (funct7=0) and OP-IMM
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_OR    = 4'b0001,
    ALU_XOR   = 4'b0010,
    ALU_ADD   = 4'b0011,
    ALU_SUB   = 4'b0100,
    ALU_MUL   = 4'b0101,
    ALU_MULH  = 4'b0110,
    ALU_MULHU = 4'b0111,
    ALU_SLL   = 4'b1000,
    ALU_SRL   = 4'b1001,
    ALU_SRA   = 4'b1010,
    ALU_SLT   = 4'b1100,
    ALU_SLTU  = 4'b1101
  } alu_op_t;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // funct3 mapping common to register-register and register-immediate forms.
  function automatic alu_op_t base_op(input logic [2:0] f3);
    alu_op_t op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_decode_comb.sv
// alu_decode_comb -- purely combinational RV32 instruction -> ALU control decode.
//   instr    : 32-bit instruction word
//   alu_op   : ALU op code (ADD for illegal instructions)
//   a_zero   : ALU A operand forced to zero (LUI)
//   b_imm    : ALU B operand taken from imm
//   imm      : sign-extended I-immediate or U-immediate, zero when illegal
//   rs1/rs2/rd : raw register index fields, always passed through
//   regwrite : legal instruction with a non-zero destination
//   illegal  : instruction not executable by the ALU
module alu_decode_comb
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output logic [3:0]  alu_op,
  output logic        a_zero,
  output logic        b_imm,
  output logic [31:0] imm,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        regwrite,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;

  alu_op_t     op_next;
  logic        legal_next;
  logic        a_zero_next;
  logic        b_imm_next;
  logic [31:0] imm_next;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    op_next     = ALU_ADD;
    legal_next  = 1'b0;
    a_zero_next = 1'b0;
    b_imm_next  = 1'b0;
    imm_next    = '0;

    case (opcode)
      OPC_OP: begin
        case (funct7)
          F7_BASE: begin
            legal_next = 1'b1;
            op_next    = base_op(funct3);
          end
          F7_ALT: begin
            if (funct3 == 3'b000) begin
              legal_next = 1'b1;
              op_next    = ALU_SUB;
            end else if (funct3 == 3'b101) begin
              legal_next = 1'b1;
              op_next    = ALU_SRA;
            end
          end
          F7_MULDIV: begin
            // MULHSU and the divide/remainder group live elsewhere.
            case (funct3)
              3'b000: begin legal_next = 1'b1; op_next = ALU_MUL;   end
              3'b001: begin legal_next = 1'b1; op_next = ALU_MULH;  end
              3'b011: begin legal_next = 1'b1; op_next = ALU_MULHU; end
              default: ;
            endcase
          end
          default: ;
        endcase
      end

      OPC_OPIMM: begin
        b_imm_next = 1'b1;
        imm_next   = {{20{instr[31]}}, instr[31:20]};
        case (funct3)
          // Shift immediates reuse the upper immediate bits as a funct7 field.
          3'b001: begin
            if (funct7 == F7_BASE) begin
              legal_next = 1'b1;
              op_next    = ALU_SLL;
            end
          end
          3'b101: begin
            if (funct7 == F7_BASE) begin
              legal_next = 1'b1;
              op_next    = ALU_SRL;
            end else if (funct7 == F7_ALT) begin
              legal_next = 1'b1;
              op_next    = ALU_SRA;
            end
          end
          default: begin
            legal_next = 1'b1;
            op_next    = base_op(funct3);
          end
        endcase
      end

      OPC_LUI: begin
        legal_next  = 1'b1;
        op_next     = ALU_ADD;
        a_zero_next = 1'b1;
        b_imm_next  = 1'b1;
        imm_next    = {instr[31:12], 12'b0};
      end

      default: ;
    endcase

    // Illegal entries present a neutral, side-effect-free control word.
    if (!legal_next) begin
      op_next     = ALU_ADD;
      a_zero_next = 1'b0;
      b_imm_next  = 1'b0;
      imm_next    = '0;
    end
  end

  assign alu_op   = op_next;
  assign a_zero   = a_zero_next;
  assign b_imm    = b_imm_next;
  assign imm      = imm_next;
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign rd       = instr[11:7];
  assign illegal  = !legal_next;
  assign regwrite = legal_next && (instr[11:7] != 5'd0);

endmodule

// File: rtl/alu_decode.sv
// alu_decode -- registered ALU decode stage with valid/ready handshake.
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_valid/in_ready : instruction handshake (in_ready = !out_valid || out_ready)
//   instr             : RV32 instruction word
//   flush             : drop the held entry and any instruction offered this cycle
//   out_valid/out_ready : decoded-entry handshake
//   alu_op, a_zero, b_imm, imm, rs1, rs2, rd, regwrite, illegal : decoded fields
//   illegal_cnt       : saturating count of accepted illegal instructions
module alu_decode
  import alu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       alu_op,
  output logic             a_zero,
  output logic             b_imm,
  output logic [31:0]      imm,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic             regwrite,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  logic [3:0]  dec_alu_op;
  logic        dec_a_zero;
  logic        dec_b_imm;
  logic [31:0] dec_imm;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic        dec_regwrite;
  logic        dec_illegal;

  alu_decode_comb u_comb (
    .instr    (instr),
    .alu_op   (dec_alu_op),
    .a_zero   (dec_a_zero),
    .b_imm    (dec_b_imm),
    .imm      (dec_imm),
    .rs1      (dec_rs1),
    .rs2      (dec_rs2),
    .rd       (dec_rd),
    .regwrite (dec_regwrite),
    .illegal  (dec_illegal)
  );

  logic             out_valid_reg;
  logic [3:0]       alu_op_reg;
  logic             a_zero_reg;
  logic             b_imm_reg;
  logic [31:0]      imm_reg;
  logic [4:0]       rs1_reg;
  logic [4:0]       rs2_reg;
  logic [4:0]       rd_reg;
  logic             regwrite_reg;
  logic             illegal_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic accept;
  logic load;

  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready;
  // flush wins over a concurrent accept: the offered instruction is discarded.
  assign load     = accept && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      alu_op_reg    <= ALU_AND;
      a_zero_reg    <= 1'b0;
      b_imm_reg     <= 1'b0;
      imm_reg       <= '0;
      rs1_reg       <= '0;
      rs2_reg       <= '0;
      rd_reg        <= '0;
      regwrite_reg  <= 1'b0;
      illegal_reg   <= 1'b0;
      cnt_reg       <= '0;
    end else begin
      if (flush) begin
        out_valid_reg <= 1'b0;
      end else if (accept) begin
        out_valid_reg <= 1'b1;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end

      if (load) begin
        alu_op_reg   <= dec_alu_op;
        a_zero_reg   <= dec_a_zero;
        b_imm_reg    <= dec_b_imm;
        imm_reg      <= dec_imm;
        rs1_reg      <= dec_rs1;
        rs2_reg      <= dec_rs2;
        rd_reg       <= dec_rd;
        regwrite_reg <= dec_regwrite;
        illegal_reg  <= dec_illegal;
      end

      if (load && dec_illegal && (cnt_reg != {CNT_W{1'b1}})) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign out_valid   = out_valid_reg;
  assign alu_op      = alu_op_reg;
  assign a_zero      = a_zero_reg;
  assign b_imm       = b_imm_reg;
  assign imm         = imm_reg;
  assign rs1         = rs1_reg;
  assign rs2         = rs2_reg;
  assign rd          = rd_reg;
  assign regwrite    = regwrite_reg;
  assign illegal     = illegal_reg;
  assign illegal_cnt = cnt_reg;

endmodule

// File: tb/tb_alu_decode.sv
// tb_alu_decode -- directed + table-driven bench for alu_decode (CNT_W=2).
// A cycle-level reference model tracks the expected output entry and counter;
// a negedge compare process checks the DUT against it every cycle, and the
// directed sequence pins hand-computed values.
module tb_alu_decode;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      instr = 32'h0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [3:0]       alu_op;
  logic             a_zero;
  logic             b_imm;
  logic [31:0]      imm;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [4:0]       rd;
  logic             regwrite;
  logic             illegal;
  logic [CNT_W-1:0] illegal_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_decode #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instr       (instr),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_op      (alu_op),
    .a_zero      (a_zero),
    .b_imm       (b_imm),
    .imm         (imm),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd),
    .regwrite    (regwrite),
    .illegal     (illegal),
    .illegal_cnt (illegal_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [3:0]  op;
    logic        a_zero;
    logic        b_imm;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        regwrite;
    logic        illegal;
  } exp_t;

  // Decode straight from the instruction-set rules.
  function automatic exp_t model_decode(input logic [31:0] i);
    exp_t        e;
    logic [6:0]  opc;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic        legal;
    logic [3:0]  tab [8];
    tab[0] = 4'h3; tab[1] = 4'h8; tab[2] = 4'hC; tab[3] = 4'hD;
    tab[4] = 4'h2; tab[5] = 4'h9; tab[6] = 4'h1; tab[7] = 4'h0;
    opc = i[6:0];
    f3  = i[14:12];
    f7  = i[31:25];
    legal    = 1'b0;
    e.op     = 4'h3;
    e.a_zero = 1'b0;
    e.b_imm  = 1'b0;
    e.imm    = 32'h0;
    e.rs1    = i[19:15];
    e.rs2    = i[24:20];
    e.rd     = i[11:7];
    if (opc == 7'h33) begin
      if (f7 == 7'h00) begin
        legal = 1'b1; e.op = tab[f3];
      end else if (f7 == 7'h20 && f3 == 3'd0) begin
        legal = 1'b1; e.op = 4'h4;
      end else if (f7 == 7'h20 && f3 == 3'd5) begin
        legal = 1'b1; e.op = 4'hA;
      end else if (f7 == 7'h01 && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd3)) begin
        legal = 1'b1; e.op = 4'h5 + ((f3 == 3'd3) ? 4'd2 : {1'b0, f3});
      end
    end else if (opc == 7'h13) begin
      e.b_imm = 1'b1;
      e.imm   = {{20{i[31]}}, i[31:20]};
      if (f3 == 3'd1) begin
        legal = (f7 == 7'h00); e.op = 4'h8;
      end else if (f3 == 3'd5) begin
        legal = (f7 == 7'h00) || (f7 == 7'h20);
        e.op  = (f7 == 7'h20) ? 4'hA : 4'h9;
      end else begin
        legal = 1'b1; e.op = tab[f3];
      end
    end else if (opc == 7'h37) begin
      legal = 1'b1; e.op = 4'h3; e.a_zero = 1'b1; e.b_imm = 1'b1;
      e.imm = {i[31:12], 12'h000};
    end
    if (!legal) begin
      e.op = 4'h3; e.a_zero = 1'b0; e.b_imm = 1'b0; e.imm = 32'h0;
    end
    e.illegal  = !legal;
    e.regwrite = legal && (e.rd != 5'd0);
    return e;
  endfunction

  logic m_valid = 1'b0;
  int   m_cnt = 0;
  exp_t m_ent;
  logic m_in_ready;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  assign m_in_ready = !m_valid || out_ready;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_cnt   <= 0;
    end else begin
      if (flush) begin
        m_valid <= 1'b0;
      end else if (in_valid && m_in_ready) begin
        exp_t d;
        d = model_decode(instr);
        m_valid <= 1'b1;
        m_ent   <= d;
        if (d.illegal && m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
        $display("txn t=%0t accept instr=%08h op=%h illegal=%0b", $time, instr, d.op, d.illegal);
      end else if (out_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  // Compare process: away from the active edge, every cycle.
  always @(negedge clk) begin
    check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    check("in_ready", {31'b0, in_ready}, {31'b0, m_in_ready});
    check("illegal_cnt", {{(32-CNT_W){1'b0}}, illegal_cnt}, m_cnt);
    if (m_valid) begin
      check("alu_op", {28'b0, alu_op}, {28'b0, m_ent.op});
      check("a_zero", {31'b0, a_zero}, {31'b0, m_ent.a_zero});
      check("b_imm", {31'b0, b_imm}, {31'b0, m_ent.b_imm});
      check("imm", imm, m_ent.imm);
      check("rs1", {27'b0, rs1}, {27'b0, m_ent.rs1});
      check("rs2", {27'b0, rs2}, {27'b0, m_ent.rs2});
      check("rd", {27'b0, rd}, {27'b0, m_ent.rd});
      check("regwrite", {31'b0, regwrite}, {31'b0, m_ent.regwrite});
      check("illegal", {31'b0, illegal}, {31'b0, m_ent.illegal});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] vec [16];

  initial begin
    vec[0]  = 32'h002081B3; // add x3,x1,x2
    vec[1]  = 32'hFFF00093; // addi x1,x0,-1
    vec[2]  = 32'h123452B7; // lui x5
    vec[3]  = 32'h4030D193; // srai x3,x1,3
    vec[4]  = 32'h0220C1B3; // div (illegal)
    vec[5]  = 32'h40208233; // sub x4,x1,x2
    vec[6]  = 32'h0020E2B3; // or x5,x1,x2
    vec[7]  = 32'h00209093; // slli x1,x1,2
    vec[8]  = 32'h02209093; // slli with bad funct7 (illegal)
    vec[9]  = 32'h4230D193; // srai with bad funct7 (illegal)
    vec[10] = 32'h0220A1B3; // mulhsu (illegal)
    vec[11] = 32'h0220B1B3; // mulhu
    vec[12] = 32'h402091B3; // funct7=0100000 f3=001 (illegal)
    vec[13] = 32'h00208033; // add x0 -> regwrite=0
    vec[14] = 32'h00208063; // beq (illegal)
    vec[15] = 32'hFFB13093; // sltiu x1,x2,-5

    // Reset state
    repeat (2) tick();
    check("rst out_valid", {31'b0, out_valid}, 32'h0);
    check("rst illegal_cnt", {30'b0, illegal_cnt}, 32'h0);
    check("rst imm", imm, 32'h0);
    check("rst rd", {27'b0, rd}, 32'h0);
    check("rst alu_op", {28'b0, alu_op}, 32'h0);
    rst_n = 1'b1;
    tick();

    // add x3,x1,x2
    out_ready = 1'b1; in_valid = 1'b1; instr = 32'h002081B3;
    tick();
    check("add out_valid", {31'b0, out_valid}, 32'h1);
    check("add alu_op", {28'b0, alu_op}, 32'h3);
    check("add b_imm", {31'b0, b_imm}, 32'h0);
    check("add rd", {27'b0, rd}, 32'd3);
    check("add rs1", {27'b0, rs1}, 32'd1);
    check("add rs2", {27'b0, rs2}, 32'd2);
    check("add regwrite", {31'b0, regwrite}, 32'h1);
    check("add illegal", {31'b0, illegal}, 32'h0);

    instr = 32'hFFF00093;
    tick();
    check("addi b_imm", {31'b0, b_imm}, 32'h1);
    check("addi imm", imm, 32'hFFFFFFFF);
    check("addi alu_op", {28'b0, alu_op}, 32'h3);

    instr = 32'h123452B7;
    tick();
    check("lui a_zero", {31'b0, a_zero}, 32'h1);
    check("lui imm", imm, 32'h12345000);
    check("lui rd", {27'b0, rd}, 32'd5);

    instr = 32'h4030D193;
    tick();
    check("srai alu_op", {28'b0, alu_op}, 32'hA);
    check("srai shamt", {27'b0, imm[4:0]}, 32'd3);

    instr = 32'h0220C1B3;
    tick();
    check("div illegal", {31'b0, illegal}, 32'h1);
    check("div regwrite", {31'b0, regwrite}, 32'h0);
    check("div cnt", {30'b0, illegal_cnt}, 32'd1);
    check("div imm", imm, 32'h0);

    // Backpressure: first held, second waits
    instr = 32'h40208233;
    tick();
    out_ready = 1'b0; instr = 32'h0020E2B3;
    #1;
    check("stall in_ready", {31'b0, in_ready}, 32'h0);
    tick();
    check("stall hold op", {28'b0, alu_op}, 32'h4);
    check("stall hold rd", {27'b0, rd}, 32'd4);
    tick();
    check("stall hold valid", {31'b0, out_valid}, 32'h1);
    check("stall hold op2", {28'b0, alu_op}, 32'h4);
    out_ready = 1'b1;
    tick();
    check("release op", {28'b0, alu_op}, 32'h1);
    check("release rd", {27'b0, rd}, 32'd5);
    in_valid = 1'b0;
    tick();
    check("no dup valid", {31'b0, out_valid}, 32'h0);

    // Flush drops held entry and concurrent illegal instr
    in_valid = 1'b1; instr = 32'h40208233;
    tick();
    instr = 32'hFFFFFFFF; flush = 1'b1;
    tick();
    check("flush out_valid", {31'b0, out_valid}, 32'h0);
    check("flush cnt", {30'b0, illegal_cnt}, 32'd1);
    flush = 1'b0; in_valid = 1'b0;
    tick();

    // Saturation: five more illegal accepts
    in_valid = 1'b1; instr = 32'h0220C1B3;
    repeat (5) tick();
    check("sat cnt", {30'b0, illegal_cnt}, 32'd3);
    in_valid = 1'b0;
    tick();

    // Table-driven mix under random handshake, checked by the model
    for (int k = 0; k < 48; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 7) == 0);
      instr     = vec[k % 16];
      tick();
    end
    flush = 1'b0;

    // Asynchronous reset in the middle of a held entry
    in_valid = 1'b1; out_ready = 1'b1; instr = 32'h002081B3;
    tick();
    check("pre-reset valid", {31'b0, out_valid}, 32'h1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async rst out_valid", {31'b0, out_valid}, 32'h0);
    check("async rst cnt", {30'b0, illegal_cnt}, 32'h0);
    in_valid = 1'b0;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
